// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports its period,
// high time and 3-bit duty code (floor(8*high/period)).
//   clk, rst     : clock, synchronous active-high reset
//   en           : enable; low returns to IDLE and clears the stuck flags
//   pwm_in       : asynchronous PWM input
//   period       : last measured period in clk cycles
//   high_time    : last measured high time in clk cycles
//   duty         : eighths-of-period duty code
//   valid        : one-cycle strobe when period/high_time/duty update
//   stuck_high/_low : line held at one level for at least TIMEOUT cycles
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [2:0]       duty,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int unsigned REM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, CALC} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [CNT_W-1:0]   cnt_p_q, cnt_p_d;
  logic [CNT_W-1:0]   h_lat_q, h_lat_d;
  logic [CNT_W-1:0]   p_lat_q, p_lat_d;
  logic [CNT_W-1:0]   div_h_q, div_h_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [1:0]         quo_q, quo_d;
  logic [1:0]         step_q, step_d;
  logic               fall_seen_q, fall_seen_d;
  logic               bad_q, bad_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_time_q, high_time_d;
  logic [2:0]         duty_q, duty_d;
  logic               valid_q, valid_d;
  logic               stuck_high_q, stuck_high_d;
  logic               stuck_low_q, stuck_low_d;

  logic               rise, fall;
  logic [REM_W-1:0]   rem_sh, p_ext, rem_nx;
  logic               q_bit;
  logic [CNT_W-1:0]   low_cnt;

  // Edge detect on the synchronised line (sync_q[1]) against its delayed copy.
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

  // One restoring-divide step; rem_q < p_lat_q so the shift cannot overflow.
  assign rem_sh = {rem_q[CNT_W-1:0], 1'b0};
  assign p_ext  = {1'b0, p_lat_q};
  assign q_bit  = (rem_sh >= p_ext);
  assign rem_nx = q_bit ? (rem_sh - p_ext) : rem_sh;

  // Cycles spent low in the current period.
  assign low_cnt = cnt_p_d - h_lat_q;

  // Next-state, datapath and output logic.
  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[1:0], pwm_in};
    h_lat_d      = h_lat_q;
    p_lat_d      = p_lat_q;
    div_h_d      = div_h_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    step_d       = step_q;
    fall_seen_d  = fall_seen_q;
    bad_d        = bad_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    // Period counter restarts at 1 after each rise and saturates.
    if (rise)                 cnt_p_d = CNT_W'(1);
    else if (&cnt_p_q)        cnt_p_d = cnt_p_q;
    else                      cnt_p_d = cnt_p_q + CNT_W'(1);

    if (rise || fall) begin
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        fall_seen_d = 1'b0;
        bad_d       = 1'b0;
        state_d     = ARM;
      end
      ARM: begin
        fall_seen_d = 1'b0;
        bad_d       = 1'b0;
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          h_lat_d = cnt_p_q;
          state_d = LOW;
        end else if (cnt_p_d >= TIMEOUT_C) begin
          stuck_high_d = 1'b1;
          bad_d        = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          if (bad_q) begin
            // Period contained a stuck condition: drop it, start timing anew.
            bad_d   = 1'b0;
            state_d = HIGH;
          end else begin
            p_lat_d     = cnt_p_q;
            div_h_d     = h_lat_q;
            rem_d       = {1'b0, h_lat_q};
            quo_d       = 2'd0;
            step_d      = 2'd0;
            fall_seen_d = 1'b0;
            state_d     = CALC;
          end
        end else if (low_cnt >= TIMEOUT_C) begin
          stuck_low_d = 1'b1;
          bad_d       = 1'b1;
        end
      end
      CALC: begin
        if (rise) begin
          // Too-short period: abort the divide and time the new period.
          fall_seen_d = 1'b0;
          bad_d       = 1'b0;
          state_d     = HIGH;
        end else begin
          if (fall) begin
            h_lat_d     = cnt_p_q;
            fall_seen_d = 1'b1;
          end
          rem_d  = rem_nx;
          quo_d  = {quo_q[0], q_bit};
          step_d = step_q + 2'd1;
          if (step_q == 2'd2) begin
            period_d    = p_lat_q;
            high_time_d = div_h_q;
            duty_d      = {quo_q, q_bit};
            valid_d     = 1'b1;
            state_d     = (fall_seen_q || fall) ? LOW : HIGH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d      = IDLE;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
      valid_d      = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      cnt_p_q      <= '0;
      h_lat_q      <= '0;
      p_lat_q      <= '0;
      div_h_q      <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      step_q       <= '0;
      fall_seen_q  <= 1'b0;
      bad_q        <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_p_q      <= cnt_p_d;
      h_lat_q      <= h_lat_d;
      p_lat_q      <= p_lat_d;
      div_h_q      <= div_h_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      step_q       <= step_d;
      fall_seen_q  <= fall_seen_d;
      bad_q        <= bad_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign duty       = duty_q;
  assign valid      = valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives PWM segment streams (directed and random),
// predicts which periods must report and when, and checks stuck flags,
// enable hold and reset-during-divide behaviour.
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  // Drive cycle of a rise -> valid cycle: 2 sync stages, 3 divide cycles, 1 register.
  localparam int LAT     = 6;
  localparam int MAX_SEG = 16;

  logic             clk = 1'b0;
  logic             rst, en, pwm_in;
  logic [CNT_W-1:0] period, high_time;
  logic [2:0]       duty;
  logic             valid, stuck_high, stuck_low;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int t;
    int p;
    int h;
    int d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   seg_p[MAX_SEG];
  int   seg_h[MAX_SEG];

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .duty       (duty),
    .valid      (valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high"},   int'(high_time), 0);
    check({tag, "_duty"},   int'(duty), 0);
    check({tag, "_valid"},  int'(valid), 0);
    check({tag, "_sh"},     int'(stuck_high), 0);
    check({tag, "_sl"},     int'(stuck_low), 0);
  endtask

  task automatic restart();
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(3);
  endtask

  // Every valid must match the head of the prediction queue, value and time.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period",    int'(period),    mon_e.p);
        check("high_time", int'(high_time), mon_e.h);
        check("duty",      int'(duty),      mon_e.d);
        check("valid_cyc", cyc,             mon_e.t);
      end
    end
  end

  // Reference model: a period reports iff it was timed from a rise that did
  // not start a divide (or was long enough to let the divide finish), had no
  // stuck phase, and the following period (if any) is at least 4 cycles.
  task automatic run_stream(input int n);
    bit ok[MAX_SEG];
    bit calc_in = 1'b0;
    for (int k = 0; k < n; k++) begin
      bit measured = !calc_in || (seg_p[k] >= 4);
      bit bad = (seg_h[k] >= TIMEOUT) || (seg_p[k] - seg_h[k] >= TIMEOUT);
      bit has_rise = (k + 1 < n);
      bit next_ok  = (k + 2 >= n) || (seg_p[k + 1] >= 4);
      ok[k]   = measured && !bad && has_rise && next_ok;
      calc_in = measured && !bad && has_rise;
    end
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      if (k > 0 && ok[k - 1])
        exp_q.push_back('{t: cyc + LAT, p: seg_p[k - 1], h: seg_h[k - 1],
                          d: (8 * seg_h[k - 1]) / seg_p[k - 1]});
      tick(seg_h[k]);
      pwm_in = 1'b0;
      tick(seg_p[k] - seg_h[k]);
    end
    tick(12);
    check("missing_valid", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic fill(input int first, input int cnt, input int p, input int h);
    for (int i = first; i < first + cnt; i++) begin
      seg_p[i] = p;
      seg_h[i] = h;
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
    tick(3);
    check_zero("rst");
    rst = 1'b0; en = 1'b1;

    // Line low from reset: stays armed, nothing reported.
    tick(200);
    check_zero("armed");

    fill(0, 6, 8, 4);   run_stream(6);
    en = 1'b0;
    tick(2);
    check("hold_period", int'(period), 8);
    check("hold_duty",   int'(duty), 4);
    en = 1'b1; tick(3);

    fill(0, 5, 10, 7);  run_stream(5);  restart();
    fill(0, 5, 8, 1);   run_stream(5);  restart();
    fill(0, 6, 4, 1);   run_stream(6);  restart();
    fill(0, 3, 8, 4);   fill(3, 3, 16, 12);  run_stream(6);

    // Long low tail of the previous stream: stuck_low, cleared by a rise.
    tick(80);
    check("stuck_low_set", int'(stuck_low), 1);
    pwm_in = 1'b1;
    tick(4);
    check("stuck_low_clr", int'(stuck_low), 0);
    pwm_in = 1'b0;
    tick(4);
    restart();

    // Random streams, periods 2..30.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 10; i++) begin
        seg_p[i] = int'($urandom_range(30, 2));
        seg_h[i] = int'($urandom_range(seg_p[i] - 1, 1));
      end
      run_stream(10);
      restart();
    end

    // Stuck high: flag exactly TIMEOUT cycles after the detected rise.
    pwm_in = 1'b1;
    t0 = cyc;
    tick(65);
    check("stuck_high_early", int'(stuck_high), 0);
    tick(1);
    check("stuck_high_set", int'(stuck_high), 1);
    tick(100 - (cyc - t0));
    pwm_in = 1'b0;
    tick(4);
    check("stuck_high_clr", int'(stuck_high), 0);
    fill(0, 4, 8, 4);   run_stream(4);
    restart();

    // Reset in the middle of the divide: result lost, outputs cleared.
    pwm_in = 1'b1; tick(4);
    pwm_in = 1'b0; tick(4);
    pwm_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check_zero("rst_calc");
    rst = 1'b0;
    pwm_in = 1'b0;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
